arilla_bus_arbiter: RTL and testbench



---
 rtl/arilla_arbiter_pkg.sv | 11 +
 rtl/rr_priority_picker.sv | 40 ++++
 rtl/arilla_bus_arbiter.sv | 118 +++++++++++
 tb/tb_arilla_bus_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/arilla_arbiter_pkg.sv
// Shared constants for the arilla bus arbiter: bus field widths and FSM state encodings.
package arilla_arbiter_pkg;

   localparam int BusAddrWidth = 32;
   localparam int BusDataWidth = 32;
   localparam int BusBeWidth   = 4;

   localparam logic [0:0] StateIdle  = 1'b0;
   localparam logic [0:0] StateIssue = 1'b1;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational arbitration picker: optional fixed priority for master 0, otherwise
// round-robin starting one past the pointer with wrap-around.
module rr_priority_picker #(
   parameter int NumMasters   = 2,
   parameter bit HighPriority = 1'b0,
   parameter int IdxW         = $clog2(NumMasters)
) (
   input  logic [NumMasters-1:0] req,
   input  logic [IdxW-1:0]       ptr,
   output logic [NumMasters-1:0] grant,
   output logic [IdxW-1:0]       idx
);

   logic [IdxW:0] cand;
   logic          found;

   // cand is one bit wider than ptr so ptr+i never overflows before the modulo fold
   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      cand  = '0;
      if (HighPriority && req[0]) begin
         grant[0] = 1'b1;
         found    = 1'b1;
      end
      for (int i = 1; i <= NumMasters; i++) begin
         cand = {1'b0, ptr} + (IdxW+1)'(i);
         if (cand >= (IdxW+1)'(NumMasters)) begin
            cand = cand - (IdxW+1)'(NumMasters);
         end
         if (!found && req[cand[IdxW-1:0]]) begin
            grant[cand[IdxW-1:0]] = 1'b1;
            idx                   = cand[IdxW-1:0];
            found                 = 1'b1;
         end
      end
   end

endmodule

// File: rtl/arilla_bus_arbiter.sv
// Shares one arilla bus slave port between several masters with round-robin or
// master-0-priority arbitration, transfer locking and a per-transfer timeout.
module arilla_bus_arbiter
   import arilla_arbiter_pkg::*;
#(
   parameter int NumMasters    = 2,
   parameter bit HighPriority  = 1'b0,
   parameter int TimeoutCycles = 255,
   localparam int OwnerW       = $clog2(NumMasters)
) (
   input  logic                                     clk,
   input  logic                                     rst_n,
   input  logic [NumMasters-1:0]                    m_req,
   input  logic [NumMasters-1:0]                    m_lock,
   input  logic [NumMasters-1:0]                    m_write,
   input  logic [NumMasters-1:0][BusAddrWidth-1:0]  m_addr,
   input  logic [NumMasters-1:0][BusDataWidth-1:0]  m_wdata,
   input  logic [NumMasters-1:0][BusBeWidth-1:0]    m_be,
   output logic [NumMasters-1:0]                    m_done,
   output logic                                     m_error,
   output logic [BusDataWidth-1:0]                  m_rdata,
   output logic                                     bus_read,
   output logic                                     bus_write,
   output logic [BusAddrWidth-1:0]                  bus_addr,
   output logic [BusDataWidth-1:0]                  bus_wdata,
   output logic [BusBeWidth-1:0]                    bus_be,
   input  logic [BusDataWidth-1:0]                  bus_rdata,
   input  logic                                     bus_available,
   output logic [OwnerW-1:0]                        owner,
   output logic                                     busy
);

   localparam int CntW = $clog2(TimeoutCycles + 1);

   logic [0:0]            state_q, state_d;
   logic [OwnerW-1:0]     owner_q, owner_d;
   logic [OwnerW-1:0]     ptr_q, ptr_d;
   logic [CntW-1:0]       count_q, count_d;
   logic [NumMasters-1:0] pick_grant;
   logic [OwnerW-1:0]     pick_idx;

   rr_priority_picker #(
      .NumMasters   (NumMasters),
      .HighPriority (HighPriority),
      .IdxW         (OwnerW)
   ) u_picker (
      .req   (m_req),
      .ptr   (ptr_q),
      .grant (pick_grant),
      .idx   (pick_idx)
   );

   assign owner     = owner_q;
   assign bus_addr  = m_addr[owner_q];
   assign bus_wdata = m_wdata[owner_q];
   assign bus_be    = m_be[owner_q];

   // Completion wins over timeout; a dropped request aborts silently with strobes low
   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      ptr_d     = ptr_q;
      count_d   = count_q;
      m_done    = '0;
      m_error   = 1'b0;
      m_rdata   = '0;
      bus_read  = 1'b0;
      bus_write = 1'b0;
      busy      = 1'b0;
      if (state_q == StateIdle) begin
         if (|pick_grant) begin
            owner_d = pick_idx;
            count_d = '0;
            state_d = StateIssue;
         end
      end else begin
         busy = 1'b1;
         if (!m_req[owner_q]) begin
            state_d = StateIdle;
         end else if (bus_available) begin
            bus_read        = !m_write[owner_q];
            bus_write       = m_write[owner_q];
            m_done[owner_q] = 1'b1;
            m_rdata         = bus_rdata;
            if (m_lock[owner_q]) begin
               count_d = '0;
            end else begin
               ptr_d   = owner_q;
               state_d = StateIdle;
            end
         end else if (count_q == CntW'(TimeoutCycles - 1)) begin
            m_done[owner_q] = 1'b1;
            m_error         = 1'b1;
            ptr_d           = owner_q;
            state_d         = StateIdle;
         end else begin
            bus_read  = !m_write[owner_q];
            bus_write = m_write[owner_q];
            count_d   = count_q + CntW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StateIdle;
         owner_q <= '0;
         ptr_q   <= OwnerW'(NumMasters - 1);
         count_q <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         count_q <= count_d;
      end
   end

endmodule

// File: tb/tb_arilla_bus_arbiter.sv
// Self-checking bench for arilla_bus_arbiter: a round-robin instance (short timeout)
// and a master-0-priority instance share stimulus; expected outputs go through a scoreboard.
module tb_arilla_bus_arbiter;

   typedef struct {
      bit          rst;
      bit          hp;
      logic [1:0]  req;
      logic [1:0]  lock;
      logic [1:0]  wr;
      logic [31:0] a1;
      logic        avail;
      logic [31:0] brdata;
      logic [1:0]  e_done;
      logic        e_err;
      logic [31:0] e_rdata;
      logic        e_rd;
      logic        e_wr;
      logic        e_busy;
      logic        e_owner;
   } vec_t;

   typedef struct {
      int   id;
      vec_t v;
   } exp_t;

   localparam logic [31:0] Addr0 = 32'h0000_0A00;

   logic               clk = 1'b0;
   logic               rst_n;
   logic [1:0]         m_req, m_lock, m_write;
   logic [1:0][31:0]   m_addr, m_wdata;
   logic [1:0][3:0]    m_be;
   logic [31:0]        bus_rdata;
   logic               bus_available;

   logic [1:0]  a_done, h_done;
   logic        a_error, h_error;
   logic [31:0] a_rdata, h_rdata, a_addr, h_addr, a_wdata, h_wdata;
   logic        a_read, h_read, a_write, h_write, a_busy, h_busy;
   logic [3:0]  a_be, h_be;
   logic [0:0]  a_owner, h_owner;

   int   n_checks = 0;
   int   n_errors = 0;
   vec_t vecs[$];
   exp_t sb[$];

   always #5 clk = ~clk;

   arilla_bus_arbiter #(.NumMasters(2), .HighPriority(1'b0), .TimeoutCycles(4)) dut (
      .clk(clk), .rst_n(rst_n), .m_req(m_req), .m_lock(m_lock), .m_write(m_write),
      .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be), .m_done(a_done), .m_error(a_error),
      .m_rdata(a_rdata), .bus_read(a_read), .bus_write(a_write), .bus_addr(a_addr),
      .bus_wdata(a_wdata), .bus_be(a_be), .bus_rdata(bus_rdata), .bus_available(bus_available),
      .owner(a_owner), .busy(a_busy)
   );

   arilla_bus_arbiter #(.NumMasters(2), .HighPriority(1'b1), .TimeoutCycles(255)) dut_hp (
      .clk(clk), .rst_n(rst_n), .m_req(m_req), .m_lock(m_lock), .m_write(m_write),
      .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be), .m_done(h_done), .m_error(h_error),
      .m_rdata(h_rdata), .bus_read(h_read), .bus_write(h_write), .bus_addr(h_addr),
      .bus_wdata(h_wdata), .bus_be(h_be), .bus_rdata(bus_rdata), .bus_available(bus_available),
      .owner(h_owner), .busy(h_busy)
   );

   function automatic vec_t mk(bit rst, bit hp, logic [1:0] req, logic [1:0] lock, logic [1:0] wr,
                               logic [31:0] a1, logic avail, logic [31:0] bd, logic [1:0] e_done,
                               logic e_err, logic [31:0] e_rdata, logic e_rd, logic e_wr,
                               logic e_busy, logic e_owner);
      vec_t v;
      v.rst = rst;  v.hp = hp;  v.req = req;  v.lock = lock;  v.wr = wr;  v.a1 = a1;
      v.avail = avail;  v.brdata = bd;  v.e_done = e_done;  v.e_err = e_err;
      v.e_rdata = e_rdata;  v.e_rd = e_rd;  v.e_wr = e_wr;  v.e_busy = e_busy;
      v.e_owner = e_owner;
      return v;
   endfunction

   function automatic vec_t mk_idle(bit rst, bit hp, logic [1:0] req, logic [1:0] lock,
                                    logic [1:0] wr, logic [31:0] a1, logic avail,
                                    logic [31:0] bd, logic own);
      return mk(rst, hp, req, lock, wr, a1, avail, bd, 2'b00, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, own);
   endfunction

   function automatic void check_output(string name, int id, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("[TB] FAIL %s (row %0d): got %h, expected %h", name, id, act, exp);
      end
   endfunction

   task automatic apply_stimulus(input vec_t v, input int id);
      exp_t e;
      @(posedge clk);
      #1;
      m_req         = v.req;
      m_lock        = v.lock;
      m_write       = v.wr;
      m_addr[1]     = v.a1;
      m_wdata[1]    = ~v.a1;
      bus_available = v.avail;
      bus_rdata     = v.brdata;
      e.id = id;
      e.v  = v;
      sb.push_back(e);
   endtask

   // Reset is asserted between clock edges so the checks prove it acts without one
   task automatic reset_dut();
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_output("rst busy", -1, a_busy, 0);
      check_output("rst done", -1, a_done, 0);
      check_output("rst strobes", -1, {a_read, a_write, a_error}, 0);
      check_output("rst owner", -1, a_owner, 0);
      check_output("rst hp busy/done", -1, {h_busy, h_done, h_read, h_write}, 0);
      m_req = '0;  m_lock = '0;  m_write = '0;  bus_available = 1'b0;  bus_rdata = '0;
      #1;
      rst_n = 1'b1;
   endtask

   always @(negedge clk) begin
      exp_t e;
      logic [31:0] exp_addr;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         exp_addr = e.v.e_owner ? e.v.a1 : Addr0;
         check_output("m_done",    e.id, e.v.hp ? h_done  : a_done,  e.v.e_done);
         check_output("m_error",   e.id, e.v.hp ? h_error : a_error, e.v.e_err);
         check_output("m_rdata",   e.id, e.v.hp ? h_rdata : a_rdata, e.v.e_rdata);
         check_output("bus_read",  e.id, e.v.hp ? h_read  : a_read,  e.v.e_rd);
         check_output("bus_write", e.id, e.v.hp ? h_write : a_write, e.v.e_wr);
         check_output("busy",      e.id, e.v.hp ? h_busy  : a_busy,  e.v.e_busy);
         check_output("owner",     e.id, e.v.hp ? h_owner : a_owner, e.v.e_owner);
         if (e.v.e_rd || e.v.e_wr) begin
            check_output("bus_addr",  e.id, e.v.hp ? h_addr  : a_addr,  exp_addr);
            check_output("bus_wdata", e.id, e.v.hp ? h_wdata : a_wdata, ~exp_addr);
            check_output("bus_be",    e.id, e.v.hp ? h_be    : a_be,    e.v.e_owner ? 4'hC : 4'h3);
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      m_req = '0;  m_lock = '0;  m_write = '0;  bus_available = 1'b0;  bus_rdata = '0;
      m_addr[0] = Addr0;  m_wdata[0] = ~Addr0;  m_addr[1] = '0;  m_wdata[1] = '0;
      m_be[0] = 4'h3;  m_be[1] = 4'hC;

      // single read from master 1, one-cycle slave
      vecs.push_back(mk_idle(1, 0, 2'b10, 2'b00, 2'b00, 32'h100, 1, 32'hDEADBEEF, 0));
      vecs.push_back(mk(0, 0, 2'b10, 2'b00, 2'b00, 32'h100, 1, 32'hDEADBEEF, 2'b10, 0, 32'hDEADBEEF, 1, 0, 1, 1));
      vecs.push_back(mk_idle(0, 0, 2'b00, 2'b00, 2'b00, 32'h100, 0, 32'h0, 1));

      // both masters requesting: alternating grants with an idle bubble between
      for (int k = 0; k < 8; k++) begin
         vecs.push_back(mk_idle(bit'(k == 0), 0, 2'b11, 2'b00, 2'b00, 32'h200, 1, 32'hA000_0000 + k,
                                (k == 0) ? 1'b0 : 1'((k + 1) % 2)));
         vecs.push_back(mk(0, 0, 2'b11, 2'b00, 2'b00, 32'h200, 1, 32'hA000_0000 + k,
                           (k % 2 == 1) ? 2'b10 : 2'b01, 0, 32'hA000_0000 + k, 1, 0, 1, 1'(k % 2)));
      end
      vecs.push_back(mk_idle(0, 0, 2'b00, 2'b00, 2'b00, 32'h200, 0, 32'h0, 1));

      // locked burst of three writes from master 1 while master 0 waits
      vecs.push_back(mk_idle(1, 0, 2'b10, 2'b10, 2'b10, 32'h10, 1, 32'h55, 0));
      vecs.push_back(mk(0, 0, 2'b11, 2'b10, 2'b10, 32'h10, 1, 32'h55, 2'b10, 0, 32'h55, 0, 1, 1, 1));
      vecs.push_back(mk(0, 0, 2'b11, 2'b10, 2'b10, 32'h14, 1, 32'h55, 2'b10, 0, 32'h55, 0, 1, 1, 1));
      vecs.push_back(mk(0, 0, 2'b11, 2'b00, 2'b10, 32'h18, 1, 32'h55, 2'b10, 0, 32'h55, 0, 1, 1, 1));
      vecs.push_back(mk_idle(0, 0, 2'b01, 2'b00, 2'b00, 32'h18, 1, 32'h66, 1));
      vecs.push_back(mk(0, 0, 2'b01, 2'b00, 2'b00, 32'h18, 1, 32'h66, 2'b01, 0, 32'h66, 1, 0, 1, 0));
      vecs.push_back(mk_idle(0, 0, 2'b00, 2'b00, 2'b00, 32'h18, 0, 32'h0, 0));

      // timeout after four ISSUE cycles, then master 1 served normally
      vecs.push_back(mk_idle(1, 0, 2'b01, 2'b00, 2'b00, 32'h300, 0, 32'h12345678, 0));
      for (int k = 0; k < 3; k++) begin
         vecs.push_back(mk(0, 0, 2'b01, 2'b00, 2'b00, 32'h300, 0, 32'h12345678, 2'b00, 0, 32'h0, 1, 0, 1, 0));
      end
      vecs.push_back(mk(0, 0, 2'b01, 2'b00, 2'b00, 32'h300, 0, 32'h12345678, 2'b01, 1, 32'h0, 0, 0, 1, 0));
      vecs.push_back(mk_idle(0, 0, 2'b10, 2'b00, 2'b00, 32'h300, 1, 32'hCAFE0001, 0));
      vecs.push_back(mk(0, 0, 2'b10, 2'b00, 2'b00, 32'h300, 1, 32'hCAFE0001, 2'b10, 0, 32'hCAFE0001, 1, 0, 1, 1));
      vecs.push_back(mk_idle(0, 0, 2'b00, 2'b00, 2'b00, 32'h300, 0, 32'h0, 1));

      // master drops its request mid-transfer: silent abort
      vecs.push_back(mk_idle(1, 0, 2'b01, 2'b00, 2'b00, 32'h300, 0, 32'h0, 0));
      vecs.push_back(mk(0, 0, 2'b01, 2'b00, 2'b00, 32'h300, 0, 32'h0, 2'b00, 0, 32'h0, 1, 0, 1, 0));
      vecs.push_back(mk(0, 0, 2'b00, 2'b00, 2'b00, 32'h300, 1, 32'h777, 2'b00, 0, 32'h0, 0, 0, 1, 0));
      vecs.push_back(mk_idle(0, 0, 2'b00, 2'b00, 2'b00, 32'h300, 0, 32'h0, 0));

      // priority instance: master 0 beats master 1 even when round-robin would not
      vecs.push_back(mk_idle(1, 1, 2'b01, 2'b00, 2'b00, 32'h500, 1, 32'h1, 0));
      vecs.push_back(mk(0, 1, 2'b01, 2'b00, 2'b00, 32'h500, 1, 32'h1, 2'b01, 0, 32'h1, 1, 0, 1, 0));
      vecs.push_back(mk_idle(0, 1, 2'b11, 2'b00, 2'b00, 32'h500, 1, 32'h2, 0));
      vecs.push_back(mk(0, 1, 2'b11, 2'b00, 2'b00, 32'h500, 1, 32'h2, 2'b01, 0, 32'h2, 1, 0, 1, 0));
      vecs.push_back(mk_idle(0, 1, 2'b10, 2'b00, 2'b00, 32'h500, 1, 32'h3, 0));
      vecs.push_back(mk(0, 1, 2'b10, 2'b00, 2'b00, 32'h500, 1, 32'h3, 2'b10, 0, 32'h3, 1, 0, 1, 1));
      vecs.push_back(mk_idle(0, 1, 2'b00, 2'b00, 2'b00, 32'h500, 0, 32'h0, 1));

      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].rst) reset_dut();
         apply_stimulus(vecs[i], i);
      end

      // asynchronous reset in the middle of a write transfer
      reset_dut();
      apply_stimulus(mk_idle(0, 0, 2'b01, 2'b00, 2'b01, 32'h400, 0, 32'h0, 0), 100);
      apply_stimulus(mk(0, 0, 2'b01, 2'b00, 2'b01, 32'h400, 0, 32'h0, 2'b00, 0, 32'h0, 0, 1, 1, 0), 101);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_output("midrst bus_write", 102, a_write, 0);
      check_output("midrst busy", 102, a_busy, 0);
      check_output("midrst done", 102, a_done, 0);
      bus_available = 1'b1;
      bus_rdata     = 32'h0BADF00D;
      #1;
      rst_n = 1'b1;
      apply_stimulus(mk(0, 0, 2'b01, 2'b00, 2'b01, 32'h400, 1, 32'h0BADF00D, 2'b01, 0, 32'h0BADF00D, 0, 1, 1, 0), 103);
      apply_stimulus(mk_idle(0, 0, 2'b00, 2'b00, 2'b00, 32'h400, 0, 32'h0, 0), 104);

      for (int i = 0; i < 4 && sb.size() > 0; i++) @(posedge clk);
      if (sb.size() > 0) begin
         n_checks++;
         n_errors++;
         $display("[TB] FAIL scoreboard drain: %0d entries left, expected 0", sb.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
